gather_credit_manager: RTL

Multi-channel, synthesizable credit tracker for gather (FC) start ports. Each of NUM_CH channels keeps a saturating credit counter: it is debited one packet's payload cost when a HEAD flit fires on that channel and credited by returns from the destination side. The block sits between the input-port arbiter, which consumes `credit_avail`, and the credit-return network, which drives the `upd_*` inputs. Optional framing checks flag protocol violations.

---
 rtl/gather_credit_pkg.sv | 63 ++++++
 rtl/gather_credit_channel.sv | 131 +++++++++++++
 rtl/gather_credit_manager.sv | 59 +++++
 3 files changed

// File: rtl/gather_credit_pkg.sv
// Shared types and the saturating credit arithmetic for gather_credit_manager.
// Flit encodings default here when the project params header is not in scope.
`ifndef HEAD
`define HEAD 2'b00
`endif
`ifndef BODY
`define BODY 2'b01
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif
`ifndef GATHER_CREDIT_ALLOC
`define GATHER_CREDIT_ALLOC 64
`endif

package gather_credit_pkg;

    localparam int unsigned DEFAULT_INIT_CREDIT = `GATHER_CREDIT_ALLOC;
    localparam int unsigned SAT_W = 32;
    localparam int unsigned SUM_W = SAT_W + 2;

    typedef enum logic [1:0] {
        FLIT_HEAD = `HEAD,
        FLIT_BODY = `BODY,
        FLIT_TAIL = `TAIL
    } flit_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_t;

    typedef struct packed {
        logic [SAT_W-1:0] value;
        logic             ovf;
        logic             unf;
    } sat_res_t;

    // cnt + amt - cost, clamped to [0, 2^cnt_w-1]; cnt_w must not exceed SAT_W.
    function automatic sat_res_t sat_update(input logic [SAT_W-1:0] cnt,
                                            input logic [SAT_W-1:0] amt,
                                            input logic [SAT_W-1:0] cost,
                                            input int unsigned      cnt_w);
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] max_v;
        sat_res_t                res;
        sum   = $signed({2'b00, cnt}) + $signed({2'b00, amt}) - $signed({2'b00, cost});
        max_v = $signed((SUM_W'(1) << cnt_w) - SUM_W'(1));
        res.ovf = 1'b0;
        res.unf = 1'b0;
        if (sum > max_v) begin
            res.value = SAT_W'(max_v);
            res.ovf   = 1'b1;
        end else if (sum < $signed(SUM_W'(0))) begin
            res.value = '0;
            res.unf   = 1'b1;
        end else begin
            res.value = SAT_W'(sum);
        end
        return res;
    endfunction

endpackage

// File: rtl/gather_credit_channel.sv
// One gather channel: saturating credit counter, sticky flags and, when
// GATHER_CREDIT_CHK_EN is defined, a packet framing checker.
module gather_credit_channel
    import gather_credit_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned INIT_CREDIT = 64,
    parameter int unsigned PKT_LEN     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             fire,
    input  logic [1:0]       flit_type,
    input  logic             inc,
    input  logic [CNT_W-1:0] amt,
    output logic [CNT_W-1:0] cnt,
    output logic             err_ovf,
    output logic             err_unf,
    output logic             err_frame
);

    localparam int unsigned PKT_COST = PKT_LEN - 2;

    flit_type_t ft;
    logic       dec_c;
    sat_res_t   sat;

    assign ft    = flit_type_t'(flit_type);
    assign dec_c = fire && (ft == FLIT_HEAD);

    always_comb begin
        sat = sat_update(SAT_W'(cnt),
                         inc   ? SAT_W'(amt)      : '0,
                         dec_c ? SAT_W'(PKT_COST) : '0,
                         CNT_W);
    end

    // Saturation keeps the bits above CNT_W zero.
    if (CNT_W < SAT_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = |sat.value[SAT_W-1:CNT_W];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= CNT_W'(INIT_CREDIT);
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else if (clear) begin
            cnt     <= CNT_W'(INIT_CREDIT);
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            cnt     <= CNT_W'(sat.value);
            err_ovf <= err_ovf | sat.ovf;
            err_unf <= err_unf | sat.unf;
        end
    end

`ifdef GATHER_CREDIT_CHK_EN
    localparam int unsigned FC_W = $clog2(PKT_LEN + 1);

    frame_state_t    state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            frame_err_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            fcnt_q    <= '0;
            err_frame <= 1'b0;
        end else if (clear) begin
            state_q   <= IDLE;
            fcnt_q    <= '0;
            err_frame <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            err_frame <= err_frame | frame_err_c;
        end
    end

    // Any violation drops back to IDLE so the next HEAD starts cleanly.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        frame_err_c = 1'b0;
        if (fire) begin
            case (state_q)
                IDLE: begin
                    if (ft == FLIT_HEAD) begin
                        state_d = IN_PKT;
                        fcnt_d  = FC_W'(1);
                    end else if (ft == FLIT_BODY || ft == FLIT_TAIL) begin
                        frame_err_c = 1'b1;
                    end
                end
                IN_PKT: begin
                    case (ft)
                        FLIT_HEAD: begin
                            frame_err_c = 1'b1;
                            state_d     = IDLE;
                            fcnt_d      = '0;
                        end
                        FLIT_BODY: begin
                            if (fcnt_q == FC_W'(PKT_LEN - 1)) begin
                                frame_err_c = 1'b1;
                                state_d     = IDLE;
                                fcnt_d      = '0;
                            end else begin
                                fcnt_d = fcnt_q + FC_W'(1);
                            end
                        end
                        FLIT_TAIL: begin
                            frame_err_c = (fcnt_q != FC_W'(PKT_LEN - 1));
                            state_d     = IDLE;
                            fcnt_d      = '0;
                        end
                        default: ;
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end
    end
`else
    assign err_frame = 1'b0;
`endif

endmodule

// File: rtl/gather_credit_manager.sv
// Per-channel credit tracker for gather start ports; framing checks are
// built in only when GATHER_CREDIT_CHK_EN is defined.
module gather_credit_manager
    import gather_credit_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned INIT_CREDIT = DEFAULT_INIT_CREDIT,
    parameter int unsigned PKT_LEN     = 16,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    fire,
    input  logic [1:0]              flit_type,
    input  logic [CH_W-1:0]         fire_ch,
    input  logic                    upd_valid,
    input  logic [CH_W-1:0]         upd_ch,
    input  logic [CNT_W-1:0]        upd_amt,
    output logic [NUM_CH*CNT_W-1:0] credit_cnt,
    output logic [NUM_CH-1:0]       credit_avail,
    output logic [NUM_CH-1:0]       err_ovf,
    output logic [NUM_CH-1:0]       err_unf,
    output logic [NUM_CH-1:0]       err_frame
);

    localparam int unsigned PKT_COST = PKT_LEN - 2;

    // Channel indices at or above NUM_CH never match a slot and are dropped.
    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
        logic fire_sel;
        logic inc_sel;

        assign fire_sel = fire && (32'(fire_ch) == 32'(c));
        assign inc_sel  = upd_valid && (32'(upd_ch) == 32'(c));

        gather_credit_channel #(
            .CNT_W       (CNT_W),
            .INIT_CREDIT (INIT_CREDIT),
            .PKT_LEN     (PKT_LEN)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .clear     (clear),
            .fire      (fire_sel),
            .flit_type (flit_type),
            .inc       (inc_sel),
            .amt       (upd_amt),
            .cnt       (credit_cnt[c*CNT_W +: CNT_W]),
            .err_ovf   (err_ovf[c]),
            .err_unf   (err_unf[c]),
            .err_frame (err_frame[c])
        );

        assign credit_avail[c] = (credit_cnt[c*CNT_W +: CNT_W] >= CNT_W'(PKT_COST));
    end

endmodule
